// File: rtl/pixel_array_ctrl.sv
// Pixel array sequencer: erase, expose and ramp conversion, then serial pixel readout over a shared bus.
// Define PIXEL_ARRAY_CTRL_GRAY_EN for a Gray-coded ramp and Gray->binary readback.
module pixel_array_ctrl #(
    parameter int N_PIXELS      = 4,
    parameter int DATA_W        = 8,
    parameter int ERASE_CYCLES  = 5,
    parameter int EXPOSE_CYCLES = 255,
    localparam int IDX_W        = (N_PIXELS > 1) ? $clog2(N_PIXELS) : 1
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                start,
    output logic                erase,
    output logic                expose,
    output logic                convert,
    output logic [DATA_W-1:0]   cnt_out,
    output logic                cnt_oe,
    output logic [N_PIXELS-1:0] read,
    input  logic [DATA_W-1:0]   data_in,
    output logic [DATA_W-1:0]   out_data,
    output logic [IDX_W-1:0]    out_idx,
    output logic                out_valid,
    input  logic                out_ready,
    output logic                busy,
    output logic                frame_done
);

    localparam int PH_MAX = (ERASE_CYCLES > EXPOSE_CYCLES) ? ERASE_CYCLES : EXPOSE_CYCLES;
    localparam int PH_W   = (PH_MAX > 1) ? $clog2(PH_MAX) : 1;
    localparam logic [PH_W-1:0]  ERASE_LOAD  = PH_W'(ERASE_CYCLES - 1);
    localparam logic [PH_W-1:0]  EXPOSE_LOAD = PH_W'(EXPOSE_CYCLES - 1);
    localparam logic [IDX_W-1:0] LAST_IDX    = IDX_W'(N_PIXELS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ERASE,
        S_EXPOSE,
        S_CONVERT,
        S_SETTLE,
        S_HOLD
    } state_t;

    state_t             state;
    state_t             next_state;
    logic [PH_W-1:0]    phase_cnt;
    logic [DATA_W-1:0]  conv_cnt;
    logic [IDX_W-1:0]   pix_idx;
    logic [DATA_W-1:0]  capture_code;
    logic               phase_done;
    logic               conv_last;
    logic               last_pixel;
    logic               handshake;

    assign phase_done = (phase_cnt == '0);
    assign conv_last  = &conv_cnt;
    assign last_pixel = (pix_idx == LAST_IDX);
    assign handshake  = (state == S_HOLD) && out_valid && out_ready;

`ifdef PIXEL_ARRAY_CTRL_GRAY_EN
    function automatic logic [DATA_W-1:0] bin2gray(input logic [DATA_W-1:0] b);
        return b ^ (b >> 1);
    endfunction

    function automatic logic [DATA_W-1:0] gray2bin(input logic [DATA_W-1:0] g);
        logic [DATA_W-1:0] b;
        b[DATA_W-1] = g[DATA_W-1];
        for (int i = DATA_W - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    assign cnt_out      = bin2gray(conv_cnt);
    assign capture_code = gray2bin(data_in);
`else
    assign cnt_out      = conv_cnt;
    assign capture_code = data_in;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        erase      = 1'b0;
        expose     = 1'b0;
        convert    = 1'b0;
        cnt_oe     = 1'b0;
        busy       = 1'b1;
        read       = '0;
        case (state)
            S_IDLE: begin
                busy = 1'b0;
                if (start) begin
                    next_state = S_ERASE;
                end
            end
            S_ERASE: begin
                erase = 1'b1;
                if (phase_done) begin
                    next_state = S_EXPOSE;
                end
            end
            S_EXPOSE: begin
                expose = 1'b1;
                if (phase_done) begin
                    next_state = S_CONVERT;
                end
            end
            S_CONVERT: begin
                convert = 1'b1;
                cnt_oe  = 1'b1;
                if (conv_last) begin
                    next_state = S_SETTLE;
                end
            end
            S_SETTLE: begin
                read       = N_PIXELS'(1) << pix_idx;
                next_state = S_HOLD;
            end
            S_HOLD: begin
                read = N_PIXELS'(1) << pix_idx;
                if (handshake) begin
                    next_state = last_pixel ? S_IDLE : S_SETTLE;
                end
            end
            default: begin
                next_state = S_IDLE;
            end
        endcase
    end

    // The ramp counter wraps back to zero on its last cycle, so it reads zero outside conversion.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            phase_cnt  <= '0;
            conv_cnt   <= '0;
            pix_idx    <= '0;
            out_data   <= '0;
            out_idx    <= '0;
            out_valid  <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        phase_cnt <= ERASE_LOAD;
                    end
                end
                S_ERASE: begin
                    phase_cnt <= phase_done ? EXPOSE_LOAD : phase_cnt - 1'b1;
                end
                S_EXPOSE: begin
                    if (!phase_done) begin
                        phase_cnt <= phase_cnt - 1'b1;
                    end
                end
                S_CONVERT: begin
                    conv_cnt <= conv_cnt + 1'b1;
                    pix_idx  <= '0;
                end
                S_SETTLE: begin
                    out_data  <= capture_code;
                    out_idx   <= pix_idx;
                    out_valid <= 1'b1;
                end
                S_HOLD: begin
                    if (handshake) begin
                        out_valid <= 1'b0;
                        if (last_pixel) begin
                            frame_done <= 1'b1;
                            pix_idx    <= '0;
                        end else begin
                            pix_idx <= pix_idx + 1'b1;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pixel_array_ctrl.sv
// Bench for pixel_array_ctrl: vector table of pixel codes, directed corner cases and random
// frames, all checked every cycle against an elapsed-time reference model.
module tb_pixel_array_ctrl;

    localparam int NP           = 4;
    localparam int DW           = 8;
    localparam int EC           = 5;
    localparam int XC           = 255;
    localparam int CONV_LEN     = 1 << DW;
    localparam int CONV_END     = EC + XC + CONV_LEN;
    localparam int FRAME_BUDGET = 2000;

    logic             clk = 1'b0;
    logic             reset_n;
    logic             start;
    logic             erase;
    logic             expose;
    logic             convert;
    logic [DW-1:0]    cnt_out;
    logic             cnt_oe;
    logic [NP-1:0]    read;
    logic [DW-1:0]    data_in;
    logic [DW-1:0]    out_data;
    logic [1:0]       out_idx;
    logic             out_valid;
    logic             out_ready;
    logic             busy;
    logic             frame_done;

    pixel_array_ctrl #(
        .N_PIXELS      (NP),
        .DATA_W        (DW),
        .ERASE_CYCLES  (EC),
        .EXPOSE_CYCLES (XC)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .start      (start),
        .erase      (erase),
        .expose     (expose),
        .convert    (convert),
        .cnt_out    (cnt_out),
        .cnt_oe     (cnt_oe),
        .read       (read),
        .data_in    (data_in),
        .out_data   (out_data),
        .out_idx    (out_idx),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .busy       (busy),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0][7:0] din;
        logic [3:0][7:0] exp;
    } vec_t;

    vec_t            vec [3];
    logic [3:0][7:0] codes;
    int              total = 0;
    int              bad = 0;
    int              cyc = 0;
    int              fd_cnt = 0;
    int              busy_cnt = 0;
    logic [7:0]      hs_data [$];
    logic [1:0]      hs_idx [$];
    int              hs_cyc [$];

    // Reference model: a frame is a count of elapsed cycles through the fixed phases, then a pixel walk.
    bit         m_active;
    bit         m_settle;
    bit         m_valid;
    bit         m_fd;
    int         m_k;
    int         m_p;
    int         m_idx;
    logic [7:0] m_data;

    function automatic logic [7:0] ramp_code(input int v);
`ifdef PIXEL_ARRAY_CTRL_GRAY_EN
        return 8'(v ^ (v >> 1));
`else
        return 8'(v);
`endif
    endfunction

    function automatic logic [7:0] bus_to_code(input logic [7:0] raw);
`ifdef PIXEL_ARRAY_CTRL_GRAY_EN
        for (int v = 0; v < CONV_LEN; v++) begin
            if (ramp_code(v) == raw) return 8'(v);
        end
        return 8'h00;
`else
        return raw;
`endif
    endfunction

    task automatic model_reset();
        m_active = 0;
        m_settle = 0;
        m_valid  = 0;
        m_fd     = 0;
        m_k      = 0;
        m_p      = 0;
        m_idx    = 0;
        m_data   = 8'h00;
    endtask

    task automatic model_advance(input logic s, input logic r, input logic [7:0] d);
        m_fd = 0;
        if (!m_active) begin
            if (s) begin
                m_active = 1;
                m_k      = 0;
            end
        end else if (m_k < CONV_END) begin
            m_k++;
            if (m_k == CONV_END) begin
                m_p      = 0;
                m_settle = 1;
            end
        end else if (m_settle) begin
            m_settle = 0;
            m_valid  = 1;
            m_data   = bus_to_code(d);
            m_idx    = m_p;
        end else if (r) begin
            m_valid = 0;
            if (m_p == NP - 1) begin
                m_active = 0;
                m_fd     = 1;
            end else begin
                m_p++;
                m_settle = 1;
            end
        end
    endtask

    function automatic logic [31:0] model_pack();
        logic       er, ex, cv;
        logic [7:0] c;
        logic [3:0] rd;
        er = m_active && (m_k < EC);
        ex = m_active && (m_k >= EC) && (m_k < EC + XC);
        cv = m_active && (m_k >= EC + XC) && (m_k < CONV_END);
        c  = cv ? ramp_code(m_k - EC - XC) : 8'h00;
        rd = (m_active && m_k >= CONV_END) ? 4'(1 << m_p) : 4'h0;
        return {3'b000, er, ex, cv, cv, m_active, m_fd, m_valid, rd, c, 2'(m_idx), m_data};
    endfunction

    function automatic logic [31:0] dut_pack();
        return {3'b000, erase, expose, convert, cnt_oe, busy, frame_done, out_valid,
                read, cnt_out, out_idx, out_data};
    endfunction

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s at cycle %0d: got %h want %h", name, cyc, act, exp);
        end
    endtask

    // One clock with the currently driven inputs; the pixel bus answers whichever pixel is selected.
    task automatic apply_stimulus();
        logic       s_q, r_q;
        logic [7:0] d_q;
        s_q = start;
        r_q = out_ready;
        d_q = data_in;
        if (out_valid && out_ready) begin
            hs_data.push_back(out_data);
            hs_idx.push_back(out_idx);
            hs_cyc.push_back(cyc);
        end
        @(posedge clk);
        #1;
        cyc++;
        if (!reset_n) model_reset();
        else model_advance(s_q, r_q, d_q);
        if (busy) busy_cnt++;
        if (frame_done) fd_cnt++;
        check_output("cycle", dut_pack(), model_pack());
        data_in = 8'h00;
        for (int i = 0; i < NP; i++) begin
            if (read == 4'(1 << i)) data_in = codes[i];
        end
    endtask

    task automatic clear_frame_stats();
        hs_data.delete();
        hs_idx.delete();
        hs_cyc.delete();
        fd_cnt   = 0;
        busy_cnt = 0;
    endtask

    task automatic launch_frame();
        start = 1'b1;
        apply_stimulus();
        start = 1'b0;
    endtask

    task automatic finish_frame();
        for (int i = 0; i < FRAME_BUDGET && m_active; i++) apply_stimulus();
        check_output("frame_end_reached", 32'(busy), 32'(0));
    endtask

    initial begin
        vec[0].din = {8'hFF, 8'hA5, 8'h07, 8'h00};
        vec[1].din = {8'h01, 8'h5A, 8'h03, 8'h80};
        vec[2].din = {8'hC0, 8'h10, 8'hAA, 8'h55};
`ifdef PIXEL_ARRAY_CTRL_GRAY_EN
        vec[0].exp = {8'hAA, 8'hC6, 8'h05, 8'h00};
        vec[1].exp = {8'h01, 8'h6C, 8'h02, 8'hFF};
        vec[2].exp = {8'h80, 8'h1F, 8'hCC, 8'h66};
`else
        vec[0].exp = vec[0].din;
        vec[1].exp = vec[1].din;
        vec[2].exp = vec[2].din;
`endif
        reset_n   = 1'b0;
        start     = 1'b0;
        out_ready = 1'b0;
        data_in   = 8'h00;
        codes     = '0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check_output("reset_state", dut_pack(), 32'h0);
        reset_n = 1'b1;
        apply_stimulus();

        // Vector table: full frames with the sink always ready.
        for (int r = 0; r < 3; r++) begin
            codes = vec[r].din;
            clear_frame_stats();
            out_ready = 1'b1;
            launch_frame();
            for (int i = 0; i < FRAME_BUDGET && !m_fd; i++) apply_stimulus();
            repeat (3) apply_stimulus();
            check_output("frame_done_count", 32'(fd_cnt), 32'(1));
            check_output("busy_cycles", 32'(busy_cnt), 32'(EC + XC + CONV_LEN + 2 * NP));
            check_output("handshakes", 32'(hs_data.size()), 32'(NP));
            for (int p = 0; p < NP && p < hs_data.size(); p++) begin
                check_output("pix_data", 32'(hs_data[p]), 32'(vec[r].exp[p]));
                check_output("pix_idx", 32'(hs_idx[p]), 32'(p));
                if (p > 0) check_output("pix_spacing", 32'(hs_cyc[p] - hs_cyc[p-1]), 32'(2));
            end
        end

        // Back-pressure on pixel 1 for ten clocks.
        codes = {8'h44, 8'h33, 8'h22, 8'h11};
        clear_frame_stats();
        out_ready = 1'b1;
        launch_frame();
        for (int i = 0; i < FRAME_BUDGET && !(read == 4'b0010 && !out_valid); i++) apply_stimulus();
        check_output("reach_pix1_settle", 32'(read), 32'h2);
        out_ready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            apply_stimulus();
            check_output("hold_read", 32'(read), 32'h2);
            check_output("hold_valid", 32'(out_valid), 32'(1));
            check_output("hold_data", 32'(out_data), 32'(bus_to_code(8'h22)));
            check_output("hold_idx", 32'(out_idx), 32'(1));
        end
        out_ready = 1'b1;
        apply_stimulus();
        check_output("pix2_settle_read", 32'(read), 32'h4);
        check_output("pix2_settle_valid", 32'(out_valid), 32'(0));
        finish_frame();
        check_output("stall_frame_done", 32'(fd_cnt), 32'(1));

        // START during EXPOSE and HOLD must be ignored.
        clear_frame_stats();
        launch_frame();
        for (int i = 0; i < FRAME_BUDGET && !expose; i++) apply_stimulus();
        repeat (10) apply_stimulus();
        launch_frame();
        for (int i = 0; i < FRAME_BUDGET && !(read == 4'b0001 && !out_valid); i++) apply_stimulus();
        out_ready = 1'b0;
        apply_stimulus();
        launch_frame();
        out_ready = 1'b1;
        finish_frame();
        repeat (600) apply_stimulus();
        check_output("ignored_start_frames", 32'(fd_cnt), 32'(1));
        check_output("ignored_start_idle", 32'(busy), 32'(0));

        // Reset at conversion count 100, then a clean restart.
        clear_frame_stats();
        launch_frame();
        for (int i = 0; i < FRAME_BUDGET && !convert; i++) apply_stimulus();
        repeat (5) apply_stimulus();
`ifdef PIXEL_ARRAY_CTRL_GRAY_EN
        check_output("ramp_count5", 32'(cnt_out), 32'h07);
`else
        check_output("ramp_count5", 32'(cnt_out), 32'h05);
`endif
        repeat (95) apply_stimulus();
        check_output("ramp_count100", 32'(cnt_out), 32'(ramp_code(100)));
        #2;
        reset_n = 1'b0;
        #1;
        model_reset();
        check_output("async_reset", dut_pack(), 32'h0);
        apply_stimulus();
        reset_n = 1'b1;
        repeat (3) apply_stimulus();
        check_output("no_done_after_reset", 32'(fd_cnt), 32'(0));
        launch_frame();
        check_output("restart_phase", 32'({erase, expose, convert}), 32'(3'b100));
        for (int i = 0; i < FRAME_BUDGET && !convert; i++) apply_stimulus();
        check_output("restart_ramp_zero", 32'(cnt_out), 32'h0);
        finish_frame();
        check_output("restart_frame_done", 32'(fd_cnt), 32'(1));

        // Random START, OUT_READY and pixel codes against the model.
        for (int i = 0; i < 4000; i++) begin
            start     = ($urandom_range(0, 19) == 0);
            out_ready = ($urandom_range(0, 9) < 6);
            if (!busy) begin
                for (int p = 0; p < NP; p++) codes[p] = 8'($urandom);
            end
            apply_stimulus();
        end
        start     = 1'b0;
        out_ready = 1'b1;
        finish_frame();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pixel_array_ctrl.md
PIXEL_ARRAY_CTRL -- requirements
Module: pixel_array_ctrl

Interface
REQ-001 Parameter N_PIXELS, default 4, number of pixels on the shared data bus (>=1).
REQ-002 Parameter DATA_W, default 8, ADC code width and bus width.
REQ-003 Parameter ERASE_CYCLES, default 5, erase phase length in clocks (>=1).
REQ-004 Parameter EXPOSE_CYCLES, default 255, expose phase length in clocks (>=1).
REQ-005 CLK  in  1  single clock; all state changes on rising edge.
REQ-006 RESET_N  in  1  reset, asynchronous, active-low.
REQ-007 START  in  1  frame request, sampled in IDLE only.
REQ-008 ERASE  out  1  pixel erase, high during ERASE state.
REQ-009 EXPOSE  out  1  pixel expose, high during EXPOSE state.
REQ-010 CONVERT  out  1  ramp enable, high during CONVERT state.
REQ-011 CNT_OUT  out  DATA_W  conversion code to the pixel bus.
REQ-012 CNT_OE  out  1  CNT_OUT drive enable, equal to CONVERT.
REQ-013 READ  out  N_PIXELS  one-hot pixel read select.
REQ-014 DATA_IN  in  DATA_W  code returned by the selected pixel.
REQ-015 OUT_DATA  out  DATA_W  captured pixel code.
REQ-016 OUT_IDX  out  clog2(N_PIXELS) (min 1)  pixel index of OUT_DATA.
REQ-017 OUT_VALID / OUT_READY  out/in  1  output handshake.
REQ-018 BUSY  out  1  high in every state except IDLE.
REQ-019 FRAME_DONE  out  1  single-cycle pulse at end of frame.

Function
REQ-020 FSM states: IDLE, ERASE, EXPOSE, CONVERT, SETTLE, HOLD; exactly one active.
REQ-021 IDLE -> ERASE on clock with START=1; START in any other state ignored, no queuing.
REQ-022 ERASE lasts ERASE_CYCLES clocks, EXPOSE lasts EXPOSE_CYCLES clocks, each via one shared phase counter reloaded on entry.
REQ-023 CONVERT lasts exactly 2^DATA_W clocks; CNT_OUT = 0 on first cycle, +1 per clock, 2^DATA_W-1 on last; no wrap observed on CNT_OUT.
REQ-024 CNT_OUT = 0 outside CONVERT.
REQ-025 After CONVERT, pixel index i = 0; SETTLE: READ[i]=1 for one clock, DATA_IN not sampled.
REQ-026 SETTLE end: DATA_IN captured into OUT_DATA, OUT_IDX = i, OUT_VALID = 1 next cycle, enter HOLD.
REQ-027 HOLD: READ[i], OUT_DATA, OUT_IDX, OUT_VALID stable until OUT_VALID & OUT_READY.
REQ-028 On handshake: OUT_VALID = 0 next cycle; if i < N_PIXELS-1, i+1 and SETTLE; else IDLE with FRAME_DONE = 1 for that one cycle.
REQ-029 OUT_READY held high: one pixel per 2 clocks; READ never has more than one bit set, all zero outside SETTLE/HOLD.
REQ-030 OUT_READY high before OUT_VALID carries no effect; OUT_VALID never drops without handshake except on reset.

Reset
REQ-031 RESET_N low asynchronously forces IDLE; ERASE, EXPOSE, CONVERT, CNT_OE, READ, OUT_VALID, FRAME_DONE, BUSY = 0; CNT_OUT, OUT_DATA, OUT_IDX = 0; counters cleared.
REQ-032 Reset mid-frame abandons the frame; no FRAME_DONE; first START after release begins a full new frame from ERASE.

Configuration
REQ-033 Macro PIXEL_ARRAY_CTRL_GRAY_EN defined: CNT_OUT is Gray code of the conversion count, DATA_IN converted Gray->binary before capture into OUT_DATA.
REQ-034 Macro undefined: CNT_OUT binary, DATA_IN captured unmodified; timing identical in both builds.

Verification
REQ-035 Defaults, START pulse, OUT_READY=1 -> ERASE 5 clocks, EXPOSE 255, CONVERT 256 with CNT_OUT 0..255, OUT_IDX 0,1,2,3 each 2 clocks apart, FRAME_DONE one pulse; BUSY high 5+255+256+8 clocks.
REQ-036 DATA_IN = 0xA5 while READ[2]=1 -> OUT_DATA = 0xA5, OUT_IDX = 2 (binary build).
REQ-037 OUT_READY=0 for 10 clocks on pixel 1 -> READ=0b0010, OUT_DATA, OUT_VALID stable all 10 clocks; pixel 2 SETTLE starts the clock after OUT_READY=1.
REQ-038 START pulsed during EXPOSE and HOLD -> no effect; exactly one frame and one FRAME_DONE.
REQ-039 RESET_N low at CONVERT count 100 -> all outputs reset values immediately; no FRAME_DONE; next START restarts from ERASE with CNT_OUT from 0.
REQ-040 PIXEL_ARRAY_CTRL_GRAY_EN build: CNT_OUT at count 5 = 0x07; DATA_IN 0x07 at read -> OUT_DATA = 0x05.
